// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO that feeds a UART transmitter. A producer pushes bytes with a
// valid/ready handshake; a small sequencer pops one byte at a time and hands
// it to the transmitter with a single-cycle write strobe. It then waits for
// the transmitter's busy flag to rise and fall before launching the next
// byte. If busy never rises within BUSY_TIMEOUT cycles, the byte is
// abandoned and timeout_err pulses.
//
// Parameters
//   DEPTH         FIFO depth in bytes (power of two, 4..256)
//   BUSY_TIMEOUT  cycles to wait for uart_tx_busy to rise after a launch
//
// Ports
//   system_clk    in   single clock, rising edge
//   reset         in   synchronous active-high reset
//   s_data        in   [7:0] byte offered by the producer
//   s_valid       in   producer offers s_data this cycle
//   s_ready       out  FIFO can accept a byte this cycle (= !full)
//   uart_din      out  [7:0] byte presented to the transmitter
//   uart_wr_en    out  one-cycle write strobe to the transmitter
//   uart_tx_busy  in   transmitter busy flag
//   count         out  [log2(DEPTH):0] bytes currently stored
//   empty         out  count == 0
//   full          out  count == DEPTH
//   overflow      out  one-cycle pulse: a byte offered while full was dropped
//   timeout_err   out  one-cycle pulse: busy did not rise after a launch
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                     system_clk,
  input  logic                     reset,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [7:0]               uart_din,
  output logic                     uart_wr_en,
  input  logic                     uart_tx_busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  // The timeout counter only has to reach BUSY_TIMEOUT-1.
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam int ONE_I      = 1;
  localparam int TMO_LAST_I = BUSY_TIMEOUT - 1;

  localparam logic [AW-1:0] PTR_ONE  = ONE_I[AW-1:0];
  localparam logic [AW:0]   CNT_ONE  = ONE_I[AW:0];
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [TW-1:0] TMO_ONE  = ONE_I[TW-1:0];
  localparam logic [TW-1:0] TMO_LAST = TMO_LAST_I[TW-1:0];

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] tmo_cnt;

  logic          push;
  logic          pop;
  logic          tmo_hit;

  // ---------------------------------------------------------------------------
  // Status flags and push qualification
  // ---------------------------------------------------------------------------
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign s_ready = !full;
  // A pop in the same cycle does not free a slot for this cycle's push:
  // s_ready depends only on the registered count.
  assign push    = s_valid && s_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop; blocking here would create order-
  // dependent simulation races.
  always_ff @(posedge system_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (pop = launch cycle, tmo_hit = last cycle of the wait)
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pop     = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      IDLE:      pop     = !empty && !uart_tx_busy;
      WAIT_BUSY: tmo_hit = !uart_tx_busy && (tmo_cnt == TMO_LAST);
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pop) state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy)  state_nxt = WAIT_DONE;
        else if (tmo_hit)  state_nxt = IDLE;   // byte is abandoned, no retry
      end
      WAIT_DONE: begin
        // Returning to IDLE here means the next launch is evaluated in the
        // following cycle at the earliest.
        if (!uart_tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the byte array has no reset; its contents are only visible through
  // the pointers and count, which are reset, so clearing it would only cost
  // a reset net on every storage bit.
  always_ff @(posedge system_clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**AW
  // ---------------------------------------------------------------------------
  always_ff @(posedge system_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;  // idle, or push and pop together
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and the busy-rise timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge system_clk) begin
    if (reset) begin
      uart_din    <= 8'h00;
      uart_wr_en  <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      // pop is only true in IDLE and IDLE is left on the same edge, so the
      // strobe can never be high on two consecutive cycles.
      uart_wr_en  <= pop;
      overflow    <= s_valid && full;
      timeout_err <= tmo_hit;
      // uart_din only changes on a launch, so it holds until the next one.
      if (pop) begin
        uart_din <= mem[rd_ptr];
      end
      if (pop) begin
        tmo_cnt <= '0;
      end else if ((state == WAIT_BUSY) && !uart_tx_busy && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TMO_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo (DEPTH=16, BUSY_TIMEOUT=15). Each scenario
// task drives stimulus and compares outputs against hand-derived values.
// tick() advances one clock, runs an optional transmitter busy model
// (busy rises 2 cycles after wr_en and lasts 20 cycles) and logs every
// uart_wr_en pulse for the scenarios that look at launch order and spacing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       system_clk;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] uart_din;
  logic       uart_wr_en;
  logic       uart_tx_busy;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       timeout_err;

  uart_tx_fifo #(.DEPTH(16), .BUSY_TIMEOUT(15)) dut (
    .system_clk   (system_clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .uart_din     (uart_din),
    .uart_wr_en   (uart_wr_en),
    .uart_tx_busy (uart_tx_busy),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .timeout_err  (timeout_err)
  );

  initial begin
    system_clk = 1'b0;
    forever #5 system_clk = ~system_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // busy model and launch log
  int         cyc = 0;
  bit         model_on = 1'b0;
  int         mdl_delay = 0;
  int         mdl_left = 0;
  int         rec_n = 0;
  logic [7:0] rec_dat [64];
  int         rec_cyc [64];
  int         rec_fall[64];
  int         fall_cyc = -1;
  int         consec_n = 0;
  bit         busy_q = 1'b0;
  bit         wr_q = 1'b0;

  // Advance to just after the next rising edge. The busy value assigned here
  // applies to the cycle that has just started.
  task automatic tick();
    @(posedge system_clk);
    #1;
    cyc++;
    if (model_on) begin
      if (uart_wr_en) mdl_delay = 3;
      if (mdl_delay != 0) begin
        mdl_delay--;
        if (mdl_delay == 0) mdl_left = 20;
      end
      if (mdl_left != 0) begin
        uart_tx_busy = 1'b1;
        mdl_left--;
      end else begin
        uart_tx_busy = 1'b0;
      end
    end
    if (busy_q && !uart_tx_busy) fall_cyc = cyc;
    if (uart_wr_en) begin
      if (wr_q) consec_n++;
      if (rec_n < 64) begin
        rec_dat[rec_n]  = uart_din;
        rec_cyc[rec_n]  = cyc;
        rec_fall[rec_n] = fall_cyc;
      end
      rec_n++;
    end
    busy_q = uart_tx_busy;
    wr_q   = uart_wr_en;
  endtask

  task automatic clear_rec();
    rec_n    = 0;
    consec_n = 0;
    fall_cyc = -1;
    busy_q   = uart_tx_busy;
    wr_q     = uart_wr_en;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    s_valid      = 1'b0;
    s_data       = 8'h00;
    model_on     = 1'b0;
    mdl_delay    = 0;
    mdl_left     = 0;
    uart_tx_busy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_rec();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 5'd0)      begin n_bad++; $display("FAIL reset.count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)      begin n_bad++; $display("FAIL reset.empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0)       begin n_bad++; $display("FAIL reset.full: got %b want 0", full); end
    n_cmp++; if (s_ready !== 1'b1)    begin n_bad++; $display("FAIL reset.s_ready: got %b want 1", s_ready); end
    n_cmp++; if (uart_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset.wr_en: got %b want 0", uart_wr_en); end
    n_cmp++; if (uart_din !== 8'h00)  begin n_bad++; $display("FAIL reset.din: got %h want 00", uart_din); end
    n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL reset.overflow: got %b want 0", overflow); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset.timeout_err: got %b want 0", timeout_err); end
  endtask

  // push A5 in cycle N with busy low: count=1 at N+1, wr_en with A5 at N+2
  task automatic test_single_byte();
    do_reset();
    s_valid = 1'b1; s_data = 8'hA5;
    tick();
    s_valid = 1'b0;
    n_cmp++; if (count !== 5'd1)      begin n_bad++; $display("FAIL single.count_n1: got %0d want 1", count); end
    n_cmp++; if (uart_wr_en !== 1'b0) begin n_bad++; $display("FAIL single.wr_en_n1: got %b want 0", uart_wr_en); end
    tick();
    n_cmp++; if (uart_wr_en !== 1'b1) begin n_bad++; $display("FAIL single.wr_en_n2: got %b want 1", uart_wr_en); end
    n_cmp++; if (uart_din !== 8'hA5)  begin n_bad++; $display("FAIL single.din: got %h want a5", uart_din); end
    n_cmp++; if (count !== 5'd0)      begin n_bad++; $display("FAIL single.count_n2: got %0d want 0", count); end
    tick();
    n_cmp++; if (uart_wr_en !== 1'b0) begin n_bad++; $display("FAIL single.wr_en_n3: got %b want 0", uart_wr_en); end
    n_cmp++; if (uart_din !== 8'hA5)  begin n_bad++; $display("FAIL single.din_hold: got %h want a5", uart_din); end
  endtask

  // fill with busy held high, then offer a 17th byte
  task automatic test_fill_overflow();
    do_reset();
    uart_tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      tick();
    end
    s_valid = 1'b0;
    n_cmp++; if (count !== 5'd16)   begin n_bad++; $display("FAIL fill.count: got %0d want 16", count); end
    n_cmp++; if (full !== 1'b1)     begin n_bad++; $display("FAIL fill.full: got %b want 1", full); end
    n_cmp++; if (s_ready !== 1'b0)  begin n_bad++; $display("FAIL fill.s_ready: got %b want 0", s_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill.overflow_pre: got %b want 0", overflow); end
    s_valid = 1'b1; s_data = 8'h10;
    tick();
    s_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill.overflow: got %b want 1", overflow); end
    n_cmp++; if (count !== 5'd16)   begin n_bad++; $display("FAIL fill.count_ovf: got %0d want 16", count); end
    tick();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill.overflow_end: got %b want 0", overflow); end
    n_cmp++; if (uart_wr_en !== 1'b0) begin n_bad++; $display("FAIL fill.wr_en_busy: got %b want 0", uart_wr_en); end
  endtask

  // three bytes through the busy model: three launches, in order, spaced
  task automatic test_back_to_back();
    do_reset();
    model_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'h31 + 8'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (100) tick();
    n_cmp++; if (rec_n !== 3)    begin n_bad++; $display("FAIL b2b.pulses: got %0d want 3", rec_n); end
    n_cmp++; if (consec_n !== 0) begin n_bad++; $display("FAIL b2b.consecutive: got %0d want 0", consec_n); end
    for (int k = 0; k < 3; k++) begin
      if (k < rec_n) begin
        n_cmp++;
        if (rec_dat[k] !== 8'h31 + 8'(k)) begin
          n_bad++; $display("FAIL b2b.data%0d: got %h want %h", k, rec_dat[k], 8'h31 + 8'(k));
        end
      end
    end
    for (int k = 1; k < 3; k++) begin
      if (k < rec_n) begin
        n_cmp++;
        if (!(rec_fall[k] > rec_cyc[k-1] && rec_cyc[k] >= rec_fall[k] + 1)) begin
          n_bad++; $display("FAIL b2b.gap%0d: launch at %0d, busy fell at %0d, previous launch %0d",
                            k, rec_cyc[k], rec_fall[k], rec_cyc[k-1]);
        end
      end
    end
    model_on = 1'b0;
  endtask

  // busy never rises: timeout_err 15 cycles after entering WAIT_BUSY (cycle E
  // of the first strobe), then the second byte launches at E+16
  task automatic test_busy_timeout();
    int stray;
    do_reset();
    s_valid = 1'b1; s_data = 8'h51;
    tick();
    s_data = 8'h52;
    tick();
    s_valid = 1'b0;
    n_cmp++; if (uart_wr_en !== 1'b1) begin n_bad++; $display("FAIL tmo.first_wr: got %b want 1", uart_wr_en); end
    n_cmp++; if (uart_din !== 8'h51)  begin n_bad++; $display("FAIL tmo.first_din: got %h want 51", uart_din); end
    n_cmp++; if (count !== 5'd1)      begin n_bad++; $display("FAIL tmo.count_e: got %0d want 1", count); end
    stray = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (timeout_err !== 1'b0 || uart_wr_en !== 1'b0) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL tmo.quiet: got %0d active cycles want 0", stray); end
    tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo.pulse: got %b want 1", timeout_err); end
    n_cmp++; if (uart_wr_en !== 1'b0)  begin n_bad++; $display("FAIL tmo.wr_at_pulse: got %b want 0", uart_wr_en); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo.pulse_end: got %b want 0", timeout_err); end
    n_cmp++; if (uart_wr_en !== 1'b1)  begin n_bad++; $display("FAIL tmo.second_wr: got %b want 1", uart_wr_en); end
    n_cmp++; if (uart_din !== 8'h52)   begin n_bad++; $display("FAIL tmo.second_din: got %h want 52", uart_din); end
    n_cmp++; if (count !== 5'd0)       begin n_bad++; $display("FAIL tmo.count_end: got %0d want 0", count); end
  endtask

  // full FIFO, pop and push in one cycle: push rejected; next push accepted;
  // then 40 bytes 80..A7 stream through, wrapping the pointers
  task automatic test_full_pop_push_wrap();
    int nxt;
    int budget;
    bit acc;
    do_reset();
    uart_tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 8'h80 + 8'(i);
      tick();
    end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL wrap.fill: got %0d want 16", count); end
    clear_rec();
    model_on = 1'b1;
    uart_tx_busy = 1'b0;
    s_valid = 1'b1; s_data = 8'hEE;
    tick();
    n_cmp++; if (count !== 5'd15)     begin n_bad++; $display("FAIL wrap.count_pop: got %0d want 15", count); end
    n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL wrap.overflow: got %b want 1", overflow); end
    n_cmp++; if (s_ready !== 1'b1)    begin n_bad++; $display("FAIL wrap.s_ready: got %b want 1", s_ready); end
    n_cmp++; if (uart_wr_en !== 1'b1) begin n_bad++; $display("FAIL wrap.wr_en: got %b want 1", uart_wr_en); end
    n_cmp++; if (uart_din !== 8'h80)  begin n_bad++; $display("FAIL wrap.din: got %h want 80", uart_din); end
    s_data = 8'h90;
    tick();
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL wrap.count_push: got %0d want 16", count); end
    n_cmp++; if (full !== 1'b1)   begin n_bad++; $display("FAIL wrap.full_again: got %b want 1", full); end
    nxt = 'h91;
    budget = 0;
    while ((rec_n < 40 || count != 5'd0) && budget < 3000) begin
      s_valid = (nxt <= 'hA7);
      s_data  = nxt[7:0];
      acc     = s_valid && s_ready;
      tick();
      if (acc) nxt++;
      budget++;
    end
    s_valid = 1'b0;
    n_cmp++; if (budget >= 3000) begin n_bad++; $display("FAIL wrap.drain_timeout: got %0d launches want 40", rec_n); end
    n_cmp++; if (rec_n !== 40)   begin n_bad++; $display("FAIL wrap.launches: got %0d want 40", rec_n); end
    n_cmp++; if (consec_n !== 0) begin n_bad++; $display("FAIL wrap.consecutive: got %0d want 0", consec_n); end
    for (int k = 0; k < 40; k++) begin
      if (k < rec_n) begin
        n_cmp++;
        if (rec_dat[k] !== 8'h80 + 8'(k)) begin
          n_bad++; $display("FAIL wrap.data%0d: got %h want %h", k, rec_dat[k], 8'h80 + 8'(k));
        end
      end
    end
    model_on = 1'b0;
  endtask

  // reset while in WAIT_DONE holding 5 bytes (with a push offered in the
  // reset cycle); nothing launches afterwards even as busy falls
  task automatic test_reset_mid_frame();
    int busy_fell;
    do_reset();
    model_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = 8'h60 + 8'(i);
      tick();
    end
    s_valid = 1'b0;
    n_cmp++; if (count !== 5'd5)        begin n_bad++; $display("FAIL rstmid.count_pre: got %0d want 5", count); end
    n_cmp++; if (uart_tx_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid.busy_pre: got %b want 1", uart_tx_busy); end
    n_cmp++; if (rec_n !== 1)           begin n_bad++; $display("FAIL rstmid.launch_pre: got %0d want 1", rec_n); end
    reset = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    tick();
    reset = 1'b0; s_valid = 1'b0;
    n_cmp++; if (count !== 5'd0)      begin n_bad++; $display("FAIL rstmid.count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1)      begin n_bad++; $display("FAIL rstmid.empty: got %b want 1", empty); end
    n_cmp++; if (uart_wr_en !== 1'b0) begin n_bad++; $display("FAIL rstmid.wr_en: got %b want 0", uart_wr_en); end
    busy_fell = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!uart_tx_busy) busy_fell = 1;
    end
    n_cmp++; if (busy_fell !== 1) begin n_bad++; $display("FAIL rstmid.busy_fell: got %0d want 1", busy_fell); end
    n_cmp++; if (rec_n !== 1)     begin n_bad++; $display("FAIL rstmid.launch_post: got %0d want 1", rec_n); end
    n_cmp++; if (count !== 5'd0)  begin n_bad++; $display("FAIL rstmid.count_post: got %0d want 0", count); end
    model_on = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    s_valid      = 1'b0;
    s_data       = 8'h00;
    uart_tx_busy = 1'b0;
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_back_to_back();
    test_busy_timeout();
    test_full_pop_push_wrap();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
